// File: rtl/fsm_stream_pkg.sv
// Types and constants shared by the bit serializer and the one-hot "101" detector.
package fsm_stream_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Detector one-hot state bit positions.
  localparam int unsigned A = 0;
  localparam int unsigned B = 1;
  localparam int unsigned C = 2;
  localparam int unsigned D = 3;
  localparam int unsigned DET_STATES = 4;

endpackage

// File: rtl/serial_word_hold.sv
// One-word holding register in front of the shifter; refilled while the
// current word is still being shifted so consecutive words stream gaplessly.
module serial_word_hold #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_word_data,
  input  logic             i_word_valid,
  input  logic             i_drain,
  output logic             o_word_ready,
  output logic [WIDTH-1:0] o_hold_data,
  output logic             o_hold_v
);

  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_v;
  logic             w_accept;

  // Ready depends only on the registered flag and reset, never on i_word_valid.
  assign o_word_ready = ~r_hold_v & ~reset;
  assign w_accept     = i_word_valid & o_word_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold_v    <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_v    <= 1'b1;
      r_hold_data <= i_word_data;
    end else if (i_drain) begin
      r_hold_v    <= 1'b0;
    end
  end

  assign o_hold_data = r_hold_data;
  assign o_hold_v    = r_hold_v;

endmodule

// File: rtl/fsm_bit_serializer.sv
// Parallel-to-serial feeder for the "101" detector: one bit per transfer,
// with last_bit marking word ends and the hold register enabling reloads.
module fsm_bit_serializer
  import fsm_stream_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_data,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             last_bit,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  ser_state_t       w_next_state;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_hold_data;
  logic             w_hold_v;
  logic             w_xfer;
  logic             w_last;
  logic             w_load;

  serial_word_hold #(.WIDTH(WIDTH)) u_hold (
    .clk          (clk),
    .reset        (reset),
    .i_word_data  (word_data),
    .i_word_valid (word_valid),
    .i_drain      (w_load),
    .o_word_ready (word_ready),
    .o_hold_data  (w_hold_data),
    .o_hold_v     (w_hold_v)
  );

  assign w_xfer = (r_state == S_SHIFT) & bit_ready;
  assign w_last = (r_cnt == CNT_LAST);
  // Load from idle, or reload straight after the final bit for gapless streaming.
  assign w_load = ((r_state == S_IDLE) & w_hold_v) | (w_xfer & w_last & w_hold_v);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_hold_v) w_next_state = S_SHIFT;
      S_SHIFT: if (w_xfer && w_last && !w_hold_v) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    last_bit  = 1'b0;
    if (r_state == S_SHIFT) begin
      bit_valid = 1'b1;
      bit_out   = MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0];
      last_bit  = w_last;
    end
  end

  assign busy = (r_state == S_SHIFT) | w_hold_v;

  // Shifter moves toward the output end with zero fill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_sh  <= w_hold_data;
      r_cnt <= '0;
    end else if (w_xfer && !w_last) begin
      r_sh  <= MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fsm_bit_serializer.sv
// Scoreboarded bench for fsm_bit_serializer: an MSB-first and an LSB-first
// instance share stimulus; the LSB instance feeds a one-hot "101" detector model.
module tb_fsm_bit_serializer;
  import fsm_stream_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] word_data;
  logic         word_valid;
  logic         bit_ready;

  logic m_word_ready, m_bit_out, m_bit_valid, m_last_bit, m_busy;
  logic l_word_ready, l_bit_out, l_bit_valid, l_last_bit, l_busy;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DET_STATES-1:0] det;
  int        det_pulses;
  int        det_pulse_cyc;
  int        l_xfers;
  int        l_xfer3_cyc;
  logic [W-1:0] l_seq;

  fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .word_data(word_data), .word_valid(word_valid),
    .word_ready(m_word_ready), .bit_out(m_bit_out), .bit_valid(m_bit_valid),
    .bit_ready(bit_ready), .last_bit(m_last_bit), .busy(m_busy)
  );

  fsm_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .word_data(word_data), .word_valid(word_valid),
    .word_ready(l_word_ready), .bit_out(l_bit_out), .bit_valid(l_bit_valid),
    .bit_ready(bit_ready), .last_bit(l_last_bit), .busy(l_busy)
  );

  always #5 clk = ~clk;

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge: push accepted words, pop/compare transferred bits.
  task automatic sample();
    exp_t e;
    logic [DET_STATES-1:0] nd;
    @(negedge clk);
    cyc++;
    if (reset) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (word_valid && m_word_ready)
        for (int i = 0; i < W; i++) q_m.push_back('{b: word_data[W-1-i], last: (i == W-1)});
      if (word_valid && l_word_ready)
        for (int i = 0; i < W; i++) q_l.push_back('{b: word_data[i], last: (i == W-1)});
      if (m_bit_valid && bit_ready) begin
        checks++;
        if (q_m.size() == 0) begin
          failures++;
          $display("FAIL msb_stream: unexpected bit=%0b last=%0b, nothing expected", m_bit_out, m_last_bit);
        end else begin
          e = q_m.pop_front();
          if (m_bit_out !== e.b || m_last_bit !== e.last) begin
            failures++;
            $display("FAIL msb_stream: got bit=%0b last=%0b expected bit=%0b last=%0b",
                     m_bit_out, m_last_bit, e.b, e.last);
          end
        end
      end
      if (det[D]) begin
        det_pulses++;
        det_pulse_cyc = cyc;
      end
      if (l_bit_valid && bit_ready) begin
        checks++;
        if (q_l.size() == 0) begin
          failures++;
          $display("FAIL lsb_stream: unexpected bit=%0b last=%0b, nothing expected", l_bit_out, l_last_bit);
        end else begin
          e = q_l.pop_front();
          if (l_bit_out !== e.b || l_last_bit !== e.last) begin
            failures++;
            $display("FAIL lsb_stream: got bit=%0b last=%0b expected bit=%0b last=%0b",
                     l_bit_out, l_last_bit, e.b, e.last);
          end
        end
        l_xfers++;
        if (l_xfers == 3) l_xfer3_cyc = cyc;
        l_seq = {l_seq[W-2:0], l_bit_out};
        nd = '0;
        if (det[A])      nd[l_bit_out ? B : A] = 1'b1;
        else if (det[B]) nd[l_bit_out ? B : C] = 1'b1;
        else if (det[C]) nd[l_bit_out ? D : A] = 1'b1;
        else             nd[l_bit_out ? B : C] = 1'b1;
        det = nd;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; word_valid = 1'b0; bit_ready = 1'b0; word_data = '0;
    drive_edge();
    sample();
    checks++;
    if ({m_word_ready, m_bit_out, m_bit_valid, m_last_bit, m_busy, l_word_ready, l_bit_valid, l_busy} !== 8'b0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%0b bit=%0b vld=%0b last=%0b busy=%0b expected all 0",
               m_word_ready, m_bit_out, m_bit_valid, m_last_bit, m_busy);
    end
    drive_edge();
    reset = 1'b0;
    sample();
    checks++;
    if ({m_word_ready, l_word_ready, m_busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_release_ready: got rdy=%0b/%0b busy=%0b expected 1/1 busy=0",
               m_word_ready, l_word_ready, m_busy);
    end
    drive_edge();
  endtask

  task automatic test_single();
    logic [W-1:0] exp;
    exp = 8'hA5;
    word_data = exp; word_valid = 1'b1; bit_ready = 1'b1;
    sample();
    checks++;
    if (m_word_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_accept: word_ready=%0b expected 1", m_word_ready);
    end
    drive_edge();
    word_valid = 1'b0;
    sample();
    checks++;
    if ({m_bit_valid, m_busy, m_word_ready} !== 3'b010) begin
      failures++;
      $display("FAIL single_latency: vld=%0b busy=%0b rdy=%0b expected 0 1 0", m_bit_valid, m_busy, m_word_ready);
    end
    drive_edge();
    for (int k = 0; k < W; k++) begin
      sample();
      checks++;
      if ({m_bit_valid, m_bit_out, m_last_bit} !== {1'b1, exp[W-1-k], (k == W-1)}) begin
        failures++;
        $display("FAIL single_bit%0d: vld=%0b bit=%0b last=%0b expected 1 %0b %0b",
                 k, m_bit_valid, m_bit_out, m_last_bit, exp[W-1-k], (k == W-1));
      end
      drive_edge();
    end
    sample();
    checks++;
    if ({m_bit_valid, m_busy, q_m.size() == 0} !== 3'b001) begin
      failures++;
      $display("FAIL single_end: vld=%0b busy=%0b pending=%0d expected 0 0 0", m_bit_valid, m_busy, q_m.size());
    end
    drive_edge();
  endtask

  task automatic test_back_to_back();
    int gaps;
    int rdy_while_held;
    gaps = 0; rdy_while_held = 0;
    word_data = 8'hA5; word_valid = 1'b1; bit_ready = 1'b1;
    sample();
    drive_edge();
    word_data = 8'h5A;
    sample();
    checks++;
    if (m_word_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_held: word_ready=%0b expected 0", m_word_ready);
    end
    drive_edge();
    sample();
    checks++;
    if ({m_word_ready, m_bit_valid} !== 2'b11) begin
      failures++;
      $display("FAIL b2b_second_accept: rdy=%0b vld=%0b expected 1 1", m_word_ready, m_bit_valid);
    end
    drive_edge();
    word_valid = 1'b0;
    for (int k = 0; k < 2*W-1; k++) begin
      sample();
      if (!m_bit_valid) gaps++;
      if (k < W-1 && m_word_ready) rdy_while_held++;
      drive_edge();
    end
    checks++;
    if (gaps != 0 || rdy_while_held != 0) begin
      failures++;
      $display("FAIL b2b_gapless: gaps=%0d ready_while_held=%0d expected 0 0", gaps, rdy_while_held);
    end
    sample();
    checks++;
    if ({m_bit_valid, q_m.size() == 0, q_l.size() == 0} !== 3'b011) begin
      failures++;
      $display("FAIL b2b_end: vld=%0b pending=%0d/%0d expected 0 0/0", m_bit_valid, q_m.size(), q_l.size());
    end
    drive_edge();
  endtask

  task automatic test_stall();
    int   xfers;
    logic prev_stalled;
    logic prev_b, prev_l;
    logic [W-1:0] got;
    xfers = 0; prev_stalled = 1'b0; prev_b = 1'b0; prev_l = 1'b0; got = '0;
    word_data = 8'hF0;
    for (int c = 0; c < 40; c++) begin
      word_valid = (c == 0);
      bit_ready  = (c % 2 == 0);
      sample();
      if (prev_stalled) begin
        checks++;
        if ({m_bit_valid, m_bit_out, m_last_bit} !== {1'b1, prev_b, prev_l}) begin
          failures++;
          $display("FAIL stall_stable: vld=%0b bit=%0b last=%0b expected 1 %0b %0b",
                   m_bit_valid, m_bit_out, m_last_bit, prev_b, prev_l);
        end
      end
      prev_stalled = m_bit_valid && !bit_ready;
      prev_b = m_bit_out;
      prev_l = m_last_bit;
      if (m_bit_valid && bit_ready) begin
        xfers++;
        got = {got[W-2:0], m_bit_out};
      end
      drive_edge();
      if (xfers == W) break;
    end
    checks++;
    if (xfers != W || got !== 8'hF0) begin
      failures++;
      $display("FAIL stall_xfers: count=%0d word=%h expected %0d f0", xfers, got, W);
    end
    word_valid = 1'b0;
    bit_ready = 1'b1;
    sample();
    checks++;
    if ({m_busy, m_bit_valid} !== 2'b00) begin
      failures++;
      $display("FAIL stall_end: busy=%0b vld=%0b expected 0 0", m_busy, m_bit_valid);
    end
    drive_edge();
  endtask

  task automatic test_stall_last();
    logic found;
    found = 1'b0;
    bit_ready = 1'b0;
    word_data = 8'h81; word_valid = 1'b1;
    sample();
    drive_edge();
    word_data = 8'h7E;
    sample();
    drive_edge();
    sample();
    drive_edge();
    word_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      bit_ready = 1'b0;
      sample();
      if (m_bit_valid && m_last_bit) begin
        found = 1'b1;
        break;
      end
      drive_edge();
      bit_ready = 1'b1;
      sample();
      drive_edge();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL stall_last_reach: last_bit never seen, expected within 30 steps");
    end
    for (int s = 0; s < 3; s++) begin
      drive_edge();
      sample();
      checks++;
      if ({m_bit_valid, m_last_bit, m_bit_out, m_word_ready} !== 4'b1110) begin
        failures++;
        $display("FAIL stall_last_hold: vld=%0b last=%0b bit=%0b rdy=%0b expected 1 1 1 0",
                 m_bit_valid, m_last_bit, m_bit_out, m_word_ready);
      end
    end
    drive_edge();
    bit_ready = 1'b1;
    sample();
    drive_edge();
    sample();
    checks++;
    if ({m_bit_valid, m_last_bit, m_bit_out, m_word_ready} !== 4'b1001) begin
      failures++;
      $display("FAIL stall_last_reload: vld=%0b last=%0b bit=%0b rdy=%0b expected 1 0 0 1",
               m_bit_valid, m_last_bit, m_bit_out, m_word_ready);
    end
    drive_edge();
    for (int k = 0; k < W; k++) begin
      sample();
      drive_edge();
    end
    sample();
    checks++;
    if ({m_busy, q_m.size() == 0, q_l.size() == 0} !== 3'b011) begin
      failures++;
      $display("FAIL stall_last_end: busy=%0b pending=%0d/%0d expected 0 0/0", m_busy, q_m.size(), q_l.size());
    end
    drive_edge();
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    bit_ready = 1'b1;
    word_data = 8'hA5; word_valid = 1'b1;
    sample();
    drive_edge();
    word_data = 8'h3C;
    sample();
    drive_edge();
    sample();
    drive_edge();
    word_valid = 1'b0;
    sample();
    drive_edge();
    sample();
    drive_edge();
    reset = 1'b1;
    sample();
    checks++;
    if ({m_bit_valid, m_word_ready} !== 2'b10) begin
      failures++;
      $display("FAIL reset_mid_4th: vld=%0b rdy=%0b expected 1 0", m_bit_valid, m_word_ready);
    end
    drive_edge();
    reset = 1'b0;
    sample();
    checks++;
    if ({m_bit_valid, m_busy, m_word_ready, m_bit_out, m_last_bit, l_bit_valid, l_busy} !== 7'b0010000) begin
      failures++;
      $display("FAIL reset_mid_after: vld=%0b busy=%0b rdy=%0b bit=%0b last=%0b expected 0 0 1 0 0",
               m_bit_valid, m_busy, m_word_ready, m_bit_out, m_last_bit);
    end
    drive_edge();
    for (int k = 0; k < 12; k++) begin
      sample();
      if (m_bit_valid || l_bit_valid || m_busy) stray++;
      drive_edge();
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL reset_mid_residual: active_cycles=%0d expected 0", stray);
    end
  endtask

  task automatic test_lsb_detector();
    det = '0;
    det[A] = 1'b1;
    det_pulses = 0; det_pulse_cyc = -1; l_xfers = 0; l_xfer3_cyc = -100; l_seq = '0;
    bit_ready = 1'b1;
    word_data = 8'h05; word_valid = 1'b1;
    sample();
    drive_edge();
    word_valid = 1'b0;
    for (int k = 0; k < W+4; k++) begin
      sample();
      drive_edge();
    end
    checks++;
    if (l_xfers != W || l_seq !== 8'hA0) begin
      failures++;
      $display("FAIL lsb_bits: count=%0d seq=%b expected %0d 10100000", l_xfers, l_seq, W);
    end
    checks++;
    if (det_pulses != 1 || det_pulse_cyc != l_xfer3_cyc + 1) begin
      failures++;
      $display("FAIL detector_pulse: pulses=%0d at_cycle=%0d expected 1 at %0d",
               det_pulses, det_pulse_cyc, l_xfer3_cyc + 1);
    end
  endtask

  initial begin
    det = '0;
    det[A] = 1'b1;
    det_pulses = 0; det_pulse_cyc = -1; l_xfers = 0; l_xfer3_cyc = -100; l_seq = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_stall_last();
    test_reset_mid();
    test_lsb_detector();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fsm_bit_serializer.md
# fsm_bit_serializer

Upstream feeder for the one-hot "101" sequence-detector FSM. It accepts parallel words over a valid/ready handshake and presents them one bit per cycle on `bit_out`, which drives the detector's `in` input. It also supplies the transfer strobe that enables the detector's one-hot state register. A one-word holding register lets consecutive words stream with no idle cycle between them.

## Interface
- `WIDTH`, default 8: word width in bits; legal range WIDTH ≥ 2.
- `MSB_FIRST`, default 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `word_data`  in  WIDTH  parallel word to serialize.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  hold register is empty; a word is accepted when `word_valid & word_ready`.
- `bit_out`  out  1  current serial bit; drives the detector `in`.
- `bit_valid`  out  1  `bit_out` is valid.
- `bit_ready`  in  1  downstream accepts the bit. The detector state enable is `bit_valid & bit_ready`.
- `last_bit`  out  1  current bit is the final bit of its word.
- `busy`  out  1  a word is held or being shifted.

## Operation
- **Storage**
  - Hold register `hold_q` with flag `hold_v`.
  - Shift register `sh_q`.
  - Bit counter `cnt_q`, width $clog2(WIDTH).
  - Two-state FSM: `S_IDLE`, `S_SHIFT`.
- **Input side**
  - `word_ready = ~hold_v & ~reset`.
  - On accept: `hold_q <= word_data`, `hold_v <= 1`.
- **S_IDLE**
  - If `hold_v`: load `sh_q <= hold_q`, `cnt_q <= 0`, clear `hold_v`, go to `S_SHIFT`.
- **S_SHIFT** (a transfer is `bit_valid & bit_ready`)
  - `bit_valid = 1`.
  - `bit_out = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]`.
  - `last_bit = (cnt_q == WIDTH-1)`.
  - Transfer with `cnt_q < WIDTH-1`: shift `sh_q` one position toward the output end, zero-fill, `cnt_q++`.
  - Transfer with `cnt_q == WIDTH-1` and `hold_v = 1`: reload the shifter from `hold_q`, `cnt_q <= 0`, clear `hold_v`, stay in `S_SHIFT` (gapless).
  - Transfer with `cnt_q == WIDTH-1` and `hold_v = 0`: go to `S_IDLE`.
  - No transfer (`bit_ready = 0`): all state holds; `bit_out` and `last_bit` stay stable.
- **Outputs outside S_SHIFT**: `bit_valid = 0`, `bit_out = 0`, `last_bit = 0`.
- `busy = (state == S_SHIFT) | hold_v`.
- **Simultaneous events**: a new word cannot be accepted in the same cycle the hold register drains, because `word_ready` comes from registered `hold_v`. It is accepted the following cycle, which still precedes the next reload because WIDTH ≥ 2.
- **Reset, including mid-word**: FSM goes to `S_IDLE`, `hold_v = 0`, `cnt_q = 0`, `sh_q = 0`. Any partial word and any held word are discarded; no residual bit is emitted.
- **Reset values**: `word_ready = 0` while `reset` is high and 1 on the first cycle after release. `bit_out`, `bit_valid`, `last_bit` and `busy` are all 0.

## Timing
- Handshake in cycle t while idle: `hold_v = 1` in t+1; first bit valid in t+2.
- With `bit_ready` held high: bits occupy cycles t+2 through t+1+WIDTH, and `last_bit` is high in t+1+WIDTH only.
- Sustained throughput: one bit per cycle with zero bubbles, provided the producer refills within WIDTH-1 cycles of `word_ready` rising.
- All outputs are decoded from registers only; `word_ready` and `bit_valid` have no combinational path from `word_valid` or `bit_ready`.

## Structure
- Shared package `fsm_stream_pkg` holds:
  - `typedef enum logic {S_IDLE, S_SHIFT} ser_state_t`.
  - Detector one-hot index constants `A=0, B=1, C=2, D=3`, shared with the detector and its state register.
- One sub-module, `serial_word_hold`: the hold register and `word_ready` logic, with a drain input driven by the FSM.

## Test plan
- Reset, then send 8'hA5 with `bit_ready = 1` (MSB_FIRST = 1) → `bit_valid` high for exactly 8 cycles starting 2 cycles after the handshake; bits 1,0,1,0,0,1,0,1; `last_bit` high on the 8th bit only.
- Send 8'hA5 then 8'h5A with `word_valid` held high → 16 consecutive valid bits with no gap; `word_ready` is low while a word is held.
- Send 8'hF0 with `bit_ready` alternating 1,0 → each bit is held stable while stalled; exactly 8 transfers in order 1,1,1,1,0,0,0,0.
- Stall on the last bit with a second word held → `last_bit` stays high and the second word is not loaded until the transfer occurs.
- Assert `reset` during the 4th bit of 8'hA5 with 8'h3C held → on the next cycle `bit_valid = 0` and `busy = 0`; `word_ready = 1` after release; no bits from either word appear.
- MSB_FIRST = 0, send 8'h05 into the detector → bits 1,0,1,0,0,0,0,0; detector `out` pulses exactly once, in the cycle after the third transfer.
